// File: rtl/pe_arr_drain.sv
// Collects one full PE-array result frame, then streams it out row-major over a
// single valid/ready port. Inputs arriving while streaming are dropped and flagged.
module pe_arr_drain #(
  parameter int rows = 8,
  parameter int cols = 8
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic [31:0]                                 in_res   [0:rows*cols-1],
  input  logic                                        in_valid [0:rows*cols-1],
  output logic [31:0]                                 out_data,
  output logic [(rows > 1 ? $clog2(rows) : 1)-1:0]    out_row,
  output logic [(cols > 1 ? $clog2(cols) : 1)-1:0]    out_col,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        out_last,
  output logic                                        busy,
  output logic                                        overrun
);

  localparam int n     = rows * cols;
  localparam int row_w = rows > 1 ? $clog2(rows) : 1;
  localparam int col_w = cols > 1 ? $clog2(cols) : 1;
  localparam int idx_w = n > 1 ? $clog2(n) : 1;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t             state, state_next;
  logic [31:0]        res_buf [0:n-1];
  logic [n-1:0]       got;
  logic [idx_w-1:0]   idx;
  logic [row_w-1:0]   row;
  logic [col_w-1:0]   col;
  logic               any_valid;
  logic               all_got;
  logic               at_last;

  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < n; k++) any_valid = any_valid | in_valid[k];
  end

  assign all_got = &got;
  assign at_last = (idx == idx_w'(n - 1));

  always_ff @(posedge clk) begin
    if (!rstn) state <= COLLECT;
    else       state <= state_next;
  end

  // A frame is settled once every element has landed and no PE is still updating.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (all_got && !any_valid) state_next = DRAIN;
      DRAIN:   if (out_ready && at_last)  state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Row/column are tracked as counters alongside idx to avoid a divider.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      got     <= '0;
      idx     <= '0;
      row     <= '0;
      col     <= '0;
      overrun <= 1'b0;
      for (int k = 0; k < n; k++) res_buf[k] <= '0;
    end else if (state == COLLECT) begin
      for (int k = 0; k < n; k++) begin
        if (in_valid[k]) begin
          res_buf[k] <= in_res[k];
          got[k]     <= 1'b1;
        end
      end
      if (state_next == DRAIN) begin
        idx <= '0;
        row <= '0;
        col <= '0;
      end
    end else begin
      if (any_valid) overrun <= 1'b1;
      if (out_ready) begin
        if (at_last) begin
          got <= '0;
          idx <= '0;
          row <= '0;
          col <= '0;
        end else begin
          idx <= idx + 1'b1;
          if (col == col_w'(cols - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  // Outputs depend only on registered state, so they hold steady while stalled.
  always_comb begin
    out_valid = (state == DRAIN);
    busy      = (state == DRAIN);
    out_data  = out_valid ? res_buf[idx] : 32'd0;
    out_row   = out_valid ? row : '0;
    out_col   = out_valid ? col : '0;
    out_last  = out_valid && at_last;
  end

endmodule

// File: tb/tb_pe_arr_drain.sv
// Bench for pe_arr_drain: frames are loaded, expected elements queued, and the
// drained stream is compared element by element against the queue.
module tb_pe_arr_drain;

  localparam int rows = 8;
  localparam int cols = 8;
  localparam int n    = rows * cols;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] in_res   [0:n-1];
  logic        in_valid [0:n-1];
  logic [31:0] out_data;
  logic [2:0]  out_row;
  logic [2:0]  out_col;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overrun;

  logic [38:0] exp_q[$];
  logic [38:0] obs_q[$];
  logic [31:0] frame_val [0:n-1];
  logic [38:0] o, e;
  int          errors = 0;
  int          checks = 0;
  int          busy_cnt;
  bit          timed_out;
  logic        busy_after;

  always #5 clk = ~clk;

  pe_arr_drain #(.rows(rows), .cols(cols)) dut (
    .clk(clk), .rstn(rstn), .in_res(in_res), .in_valid(in_valid),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overrun(overrun)
  );

  task automatic idle_inputs();
    for (int k = 0; k < n; k++) begin
      in_valid[k] = 1'b0;
      in_res[k]   = 32'd0;
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < n; k++)
      exp_q.push_back({frame_val[k], 3'(k / cols), 3'(k % cols), 1'(k == n - 1)});
  endtask

  // Called at a negedge: present frame_val with all valids for 'hold' cycles, then drop.
  task automatic load_frame(input int hold);
    for (int k = 0; k < n; k++) begin
      in_res[k]   = frame_val[k];
      in_valid[k] = 1'b1;
    end
    repeat (hold) @(negedge clk);
    idle_inputs();
  endtask

  // Called at a negedge: accept every element with ready high until out_last.
  task automatic collect();
    obs_q.delete();
    busy_cnt   = 0;
    timed_out  = 1'b1;
    busy_after = 1'bx;
    for (int i = 0; i < 1000; i++) begin
      out_ready = 1'b1;
      if (busy) busy_cnt++;
      if (out_valid) begin
        obs_q.push_back({out_data, out_row, out_col, out_last});
        if (out_last) begin
          timed_out = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    if (!timed_out) @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if ({out_valid, busy, overrun, out_last} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got v=%b b=%b o=%b l=%b exp all 0", out_valid, busy, overrun, out_last); end
    checks++; if (out_data !== 32'd0) begin errors++;
      $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if ({out_row, out_col} !== 6'd0) begin errors++;
      $display("FAIL reset_rowcol got %0d,%0d exp 0,0", out_row, out_col); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_empty_nodrain got busy=%b exp 0", busy); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < n; k++) frame_val[k] = 32'(k + 1);
    push_frame();
    load_frame(3);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL basic_early_drain got busy=%b exp 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || out_data !== 32'd1) begin errors++;
      $display("FAIL basic_entry got busy=%b data=%h exp 1,1", busy, out_data); end
    collect();
    checks++; if (timed_out || busy_cnt != n || busy_after !== 1'b0) begin errors++;
      $display("FAIL basic_timing got to=%0d busy_cycles=%0d busy_after=%b exp 0,64,0", timed_out, busy_cnt, busy_after); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra got %h exp none", o); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL basic_elem got %h exp %h", o, e); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL basic_missing got %0d left exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_stall();
    logic [39:0] prev, cur;
    bit prev_stalled, started, done;
    for (int k = 0; k < n; k++) frame_val[k] = 32'(k + 1);
    push_frame();
    load_frame(1);
    obs_q.delete();
    prev_stalled = 1'b0; started = 1'b0; done = 1'b0; prev = '0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      cur = {out_valid, out_data, out_row, out_col, out_last};
      if (prev_stalled) begin
        checks++; if (cur !== prev) begin errors++;
          $display("FAIL stall_hold got %h exp %h", cur, prev); end
      end
      if (started && !out_valid) begin
        checks++; errors++;
        $display("FAIL stall_valid_drop got out_valid=0 exp 1");
        done = 1'b1;
      end
      if (out_valid) started = 1'b1;
      if (out_valid && out_ready) begin
        obs_q.push_back({out_data, out_row, out_col, out_last});
        if (out_last) done = 1'b1;
      end
      prev_stalled = out_valid && !out_ready;
      prev = cur;
    end
    checks++; if (!done) begin errors++; $display("FAIL stall_timeout got no out_last exp out_last"); end
    out_ready = 1'b1;
    @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL stall_extra got %h exp none", o); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL stall_elem got %h exp %h", o, e); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL stall_missing got %0d left exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_stagger();
    for (int k = 0; k < n; k++) frame_val[k] = 32'(100 * (k / cols) + (k % cols));
    push_frame();
    for (int r = 0; r < rows; r++) begin
      checks++; if (busy !== 1'b0) begin errors++;
        $display("FAIL stagger_early row=%0d got busy=%b exp 0", r, busy); end
      for (int k = 0; k < n; k++) begin
        in_valid[k] = (k / cols == r);
        in_res[k]   = frame_val[k];
      end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL stagger_row7_pending got busy=%b exp 0", busy); end
    idle_inputs();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL stagger_entry got busy=%b exp 1", busy); end
    collect();
    checks++; if (timed_out || busy_cnt != n) begin errors++;
      $display("FAIL stagger_timing got to=%0d busy_cycles=%0d exp 0,64", timed_out, busy_cnt); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL stagger_extra got %h exp none", o); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL stagger_elem got %h exp %h", o, e); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL stagger_missing got %0d left exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_hold_latest();
    for (int k = 0; k < n; k++) frame_val[k] = 32'(k + 1);
    frame_val[5] = 32'd9;
    push_frame();
    for (int k = 0; k < n; k++) begin
      in_valid[k] = 1'b1;
      in_res[k]   = 32'(k + 1);
    end
    in_res[5] = 32'd7;
    @(negedge clk);
    idle_inputs();
    for (int v = 8; v <= 9; v++) begin
      checks++; if (busy !== 1'b0) begin errors++;
        $display("FAIL hold_early v=%0d got busy=%b exp 0", v, busy); end
      in_valid[5] = 1'b1;
      in_res[5]   = 32'(v);
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL hold_last_pending got busy=%b exp 0", busy); end
    idle_inputs();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL hold_entry got busy=%b exp 1", busy); end
    collect();
    checks++; if (timed_out) begin errors++; $display("FAIL hold_timeout got no out_last exp out_last"); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL hold_extra got %h exp none", o); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL hold_elem got %h exp %h", o, e); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL hold_missing got %0d left exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_overrun();
    for (int k = 0; k < n; k++) frame_val[k] = 32'(k + 1);
    push_frame();
    load_frame(1);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || overrun !== 1'b0) begin errors++;
      $display("FAIL ovr_entry got busy=%b ovr=%b exp 1,0", busy, overrun); end
    out_ready   = 1'b0;
    in_valid[0] = 1'b1;
    in_res[0]   = 32'hDEAD;
    @(negedge clk);
    checks++; if (overrun !== 1'b1) begin errors++;
      $display("FAIL ovr_set got %b exp 1", overrun); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin errors++;
      $display("FAIL ovr_elem0 got v=%b data=%h exp 1,1", out_valid, out_data); end
    idle_inputs();
    collect();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL ovr_extra got %h exp none", o); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL ovr_elem got %h exp %h", o, e); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL ovr_missing got %0d left exp 0", exp_q.size()); exp_q.delete(); end
    for (int k = 0; k < n; k++) frame_val[k] = 32'(k + 1000);
    push_frame();
    load_frame(1);
    @(negedge clk);
    collect();
    checks++; if (timed_out || overrun !== 1'b1) begin errors++;
      $display("FAIL ovr_next_frame got to=%0d ovr=%b exp 0,1", timed_out, overrun); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL ovr2_extra got %h exp none", o); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL ovr2_elem got %h exp %h", o, e); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL ovr2_missing got %0d left exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < n; k++) frame_val[k] = 32'(k + 1);
    load_frame(1);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (out_data !== 32'd21 || out_row !== 3'd2 || out_col !== 3'd4) begin errors++;
      $display("FAIL mid_elem20 got data=%h rc=%0d,%0d exp 21,2,4", out_data, out_row, out_col); end
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL mid_reset got v=%b ovr=%b busy=%b exp 0,0,0", out_valid, overrun, busy); end
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++;
        $display("FAIL mid_after_reset cycle=%0d got v=%b exp 0", i, out_valid); end
    end
    for (int k = 0; k < n; k++) frame_val[k] = $urandom_range(32'hFFFF_FFFF, 0);
    push_frame();
    load_frame(1);
    @(negedge clk);
    collect();
    checks++; if (timed_out || busy_cnt != n) begin errors++;
      $display("FAIL mid_fresh_timing got to=%0d busy_cycles=%0d exp 0,64", timed_out, busy_cnt); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL mid_extra got %h exp none", o); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL mid_elem got %h exp %h", o, e); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL mid_missing got %0d left exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < n; k++) frame_val[k] = $urandom_range(32'hFFFF_FFFF, 0);
      push_frame();
      load_frame(1);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++;
        $display("FAIL b2b_entry frame=%0d got busy=%b exp 1", f, busy); end
      collect();
      checks++; if (timed_out || busy_after !== 1'b0) begin errors++;
        $display("FAIL b2b_timing frame=%0d got to=%0d busy_after=%b exp 0,0", f, timed_out, busy_after); end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front(); checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra got %h exp none", o); end
        else begin e = exp_q.pop_front();
          if (o !== e) begin errors++; $display("FAIL b2b_elem frame=%0d got %h exp %h", f, o, e); end end
      end
      checks++; if (exp_q.size() != 0) begin errors++;
        $display("FAIL b2b_missing got %0d left exp 0", exp_q.size()); exp_q.delete(); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_stagger();
    test_hold_latest();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
